// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns EX/MEM load/store controls into a registered dcache
// request, stalls until dhit, captures load data and tracks the LL/SC link.
module mem_stage_ctrl #(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memren_in,
  input  logic              memwen_in,
  input  logic              datomic_in,
  input  logic [WORD_W-1:0] aluout_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] sc_result,
  output logic              mem_done,
  output logic              link_valid,
  output logic              timeout_err
);

  // state  | meaning
  // IDLE   | waiting for a load/store from EX/MEM
  // ACCESS | dcache request outstanding until dhit
  // DONE   | access retired, mem_done pulse, inputs ignored
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t            r_state, w_next_state;
  logic [WORD_W-1:2] r_addr, r_link_addr;
  logic [WORD_W-1:0] r_store, r_load_data;
  logic              r_is_load, r_is_atomic, r_link_valid, r_sc_result, r_timeout;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic w_req, w_sc_req, w_sc_fail, w_hit_done, w_ll_commit;
  logic w_snoop_link, w_snoop_ll;
  logic w_unused;

  assign w_req        = memren_in | memwen_in;
  assign w_sc_req     = memwen_in & ~memren_in & datomic_in;
  assign w_sc_fail    = w_sc_req & ~(r_link_valid & (aluout_in[WORD_W-1:2] == r_link_addr));
  assign w_hit_done   = (r_state == ACCESS) & dhit;
  assign w_ll_commit  = w_hit_done & r_is_load & r_is_atomic;
  assign w_snoop_link = ccinv & (ccsnoopaddr[WORD_W-1:2] == r_link_addr);
  // An LL retiring this cycle installs r_addr, so the snoop is judged against that.
  assign w_snoop_ll   = ccinv & (ccsnoopaddr[WORD_W-1:2] == r_addr);
  assign w_unused     = ^{aluout_in[1:0], ccsnoopaddr[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    dmemaddr     = '0;
    dmemstore    = '0;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    case (r_state)
      IDLE: begin
        mem_stall = w_req;
        if (w_req) w_next_state = w_sc_fail ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_stall = 1'b1;
        dmemREN   = r_is_load;
        dmemWEN   = ~r_is_load;
        dmemaddr  = {r_addr, 2'b00};
        dmemstore = r_store;
        if (dhit) w_next_state = DONE;
      end
      DONE: begin
        mem_done     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr       <= '0;
      r_store      <= '0;
      r_is_load    <= 1'b0;
      r_is_atomic  <= 1'b0;
      r_load_data  <= '0;
      r_sc_result  <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
      r_wait_cnt   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr      <= aluout_in[WORD_W-1:2];
            r_store     <= store_in;
            r_is_load   <= memren_in;
            r_is_atomic <= datomic_in;
            if (w_sc_fail) r_sc_result <= 1'b0;
          end
        end
        ACCESS: begin
          if (dhit) begin
            r_wait_cnt <= '0;
            if (r_is_load) begin
              r_load_data <= dmemload;
              if (r_is_atomic) begin
                r_link_valid <= ~w_snoop_ll;
                r_link_addr  <= r_addr;
              end
            end else if (r_is_atomic) begin
              r_sc_result  <= 1'b1;
              r_link_valid <= 1'b0;
            end else if (r_addr == r_link_addr) begin
              r_link_valid <= 1'b0;
            end
          end else begin
            if (r_wait_cnt != CNT_MAX)  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (r_wait_cnt == CNT_LAST) r_timeout  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_snoop_link && !w_ll_commit) r_link_valid <= 1'b0;
    end
  end

  assign load_data   = r_load_data;
  assign sc_result   = {{(WORD_W-1){1'b0}}, r_sc_result};
  assign link_valid  = r_link_valid;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: op-level reference model feeds expectations,
// a negedge monitor checks every retired access.
module tb_mem_stage_ctrl;
  localparam int W  = 32;
  localparam int MW = 255;

  logic CLK = 1'b0;
  logic nRST;
  logic memren_in, memwen_in, datomic_in, dhit;
  logic [W-1:0] aluout_in, store_in, dmemload;
  logic ccinv;
  logic [W-1:0] ccsnoopaddr;
  logic dmemREN, dmemWEN, mem_stall, mem_done, link_valid, timeout_err;
  logic [W-1:0] dmemaddr, dmemstore, load_data, sc_result;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.WORD_W(W), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .nRST(nRST),
    .memren_in(memren_in), .memwen_in(memwen_in), .datomic_in(datomic_in),
    .aluout_in(aluout_in), .store_in(store_in),
    .dhit(dhit), .dmemload(dmemload),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .load_data(load_data), .sc_result(sc_result),
    .mem_done(mem_done), .link_valid(link_valid), .timeout_err(timeout_err)
  );

  // snoop sources: idle snoops from the driver, dhit-aligned snoops from the dcache model
  logic drv_ccinv = 1'b0, hit_ccinv = 1'b0;
  logic [W-1:0] drv_snoop_addr = '0, hit_snoop_addr = '0;
  assign ccinv       = drv_ccinv | hit_ccinv;
  assign ccsnoopaddr = hit_ccinv ? hit_snoop_addr : drv_snoop_addr;

  typedef struct {
    logic [31:0] ld;
    logic [31:0] sc;
    logic        lv;
    int          ren;
    int          wen;
    int          stall;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] cache_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h300, 32'h2F0};

  // reference model state (architectural view)
  logic        m_lv = 1'b0;
  logic [31:0] m_la = '0, m_ld = '0;
  logic        m_sc = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] rd_cache(input logic [31:0] a);
    if (cache_mem.exists(a)) return cache_mem[a];
    return init_word(a);
  endfunction
  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // dcache model: answers after cur_lat request cycles (0 = never)
  int cur_lat = 1;
  logic hit_snoop_en = 1'b0;
  int acc_cnt = 0;
  initial begin dhit = 1'b0; dmemload = '0; end
  always begin
    @(posedge CLK); #1;
    if (!nRST || !(dmemREN || dmemWEN)) begin
      acc_cnt = 0; dhit = 1'b0; hit_ccinv = 1'b0;
    end else begin
      acc_cnt++;
      if (cur_lat != 0 && acc_cnt == cur_lat) begin
        dhit = 1'b1;
        if (dmemREN) dmemload = rd_cache(dmemaddr);
        else         cache_mem[dmemaddr] = dmemstore;
        hit_ccinv = hit_snoop_en;
      end else begin
        dhit = 1'b0; hit_ccinv = 1'b0; dmemload = $urandom;
      end
    end
  end

  // monitor: accumulate per-access activity, check on each mem_done
  int mon_ren = 0, mon_wen = 0, mon_stall = 0;
  logic [31:0] mon_addr = '0, mon_wdata = '0;
  exp_t me;
  always @(negedge CLK) begin
    if (!nRST) begin
      mon_ren = 0; mon_wen = 0; mon_stall = 0;
    end else begin
      if (mem_stall) mon_stall++;
      if (dmemREN) begin mon_ren++; mon_addr = dmemaddr; end
      if (dmemWEN) begin mon_wen++; mon_addr = dmemaddr; mon_wdata = dmemstore; end
      if (mem_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_mem_done", 32'(mem_done), 32'd0);
        end else begin
          me = sbq.pop_front();
          chk("load_data", load_data, me.ld);
          chk("sc_result", sc_result, me.sc);
          chk("link_valid", 32'(link_valid), 32'(me.lv));
          chk("ren_cycles", 32'(mon_ren), 32'(me.ren));
          chk("wen_cycles", 32'(mon_wen), 32'(me.wen));
          chk("stall_cycles", 32'(mon_stall), 32'(me.stall));
          chk("timeout_err_idle", 32'(timeout_err), 32'd0);
          if (me.ren + me.wen > 0) chk("dmemaddr", mon_addr, me.addr);
          if (me.wen > 0)          chk("dmemstore", mon_wdata, me.wdata);
        end
        mon_ren = 0; mon_wen = 0; mon_stall = 0;
      end
    end
  end

  task automatic do_op(input bit rd, input bit wr, input bit at, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input bit snp, input logic [31:0] snp_a);
    exp_t e;
    logic [31:0] wa;
    bit match;
    int budget;
    wa = {a[31:2], 2'b00};
    match = m_lv && (wa[31:2] == m_la[31:2]);
    e.addr = wa; e.wdata = '0; e.ren = 0; e.wen = 0;
    if (!rd && wr && at && !match) begin
      m_sc = 1'b0;
      e.stall = 1;
    end else begin
      e.stall = lat + 1;
      if (rd) begin
        e.ren = lat;
        m_ld = rd_ref(wa);
        if (at) begin m_la = wa; m_lv = 1'b1; end
      end else begin
        e.wen = lat; e.wdata = d;
        ref_mem[wa] = d;
        if (at) begin m_sc = 1'b1; m_lv = 1'b0; end
        else if (match) m_lv = 1'b0;
      end
      if (snp && m_lv && snp_a[31:2] == m_la[31:2]) m_lv = 1'b0;
    end
    e.ld = m_ld; e.sc = {31'd0, m_sc}; e.lv = m_lv;
    sbq.push_back(e);
    cur_lat = lat; hit_snoop_en = snp; hit_snoop_addr = snp_a;
    memren_in = rd; memwen_in = wr; datomic_in = at; aluout_in = a; store_in = d;
    budget = 0;
    do begin
      @(posedge CLK); #1;
      budget++;
    end while (!mem_done && budget < lat + 20);
    chk("op_completed", 32'(mem_done), 32'd1);
    memren_in = 1'b0; memwen_in = 1'b0; datomic_in = 1'b0; hit_snoop_en = 1'b0;
  endtask

  task automatic snoop_idle(input logic [31:0] a);
    drv_snoop_addr = a; drv_ccinv = 1'b1;
    if (m_lv && a[31:2] == m_la[31:2]) m_lv = 1'b0;
    @(posedge CLK); #1;
    drv_ccinv = 1'b0;
    chk("link_after_snoop", 32'(link_valid), 32'(m_lv));
  endtask

  initial begin
    int k;
    bit rd, wr, at, snp;
    nRST = 1'b1;
    memren_in = 1'b0; memwen_in = 1'b0; datomic_in = 1'b0;
    aluout_in = '0; store_in = '0;
    #2 nRST = 1'b0;
    repeat (2) @(posedge CLK); #1;
    chk("rst_dmemREN", 32'(dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_link_valid", 32'(link_valid), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_sc_result", sc_result, 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    do_op(1, 0, 0, 32'h100, 32'h0, 3, 0, 32'h0);          // LW, dhit after 3
    do_op(0, 1, 0, 32'h200, 32'hDEADBEEF, 1, 0, 32'h0);   // SW
    do_op(1, 0, 0, 32'h202, 32'h0, 2, 0, 32'h0);          // reload stored word, low bits ignored
    do_op(1, 0, 1, 32'h300, 32'h0, 2, 0, 32'h0);          // LL
    do_op(0, 1, 1, 32'h302, 32'h1234_5678, 2, 0, 32'h0);  // SC succeeds
    do_op(1, 0, 1, 32'h300, 32'h0, 1, 0, 32'h0);          // LL
    snoop_idle(32'h300);
    do_op(0, 1, 1, 32'h300, 32'h55, 1, 0, 32'h0);         // SC fails, no access
    do_op(1, 0, 1, 32'h300, 32'h0, 2, 1, 32'h301);        // LL with same-cycle snoop
    do_op(0, 1, 1, 32'h300, 32'h66, 1, 0, 32'h0);         // SC fails
    do_op(1, 1, 1, 32'h104, 32'h77, 2, 0, 32'h0);         // both set: LL
    do_op(0, 1, 1, 32'h107, 32'h88, 3, 1, 32'h104);       // SC + snoop: success, link invalid
    do_op(1, 0, 1, 32'h2F0, 32'h0, 1, 0, 32'h0);
    do_op(0, 1, 0, 32'h2F0, 32'h99, 1, 0, 32'h0);         // plain store kills link
    do_op(0, 1, 1, 32'h2F0, 32'hAA, 1, 0, 32'h0);         // SC fails

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      rd = (k <= 3) || (k == 7);
      wr = !rd || (k == 7);
      at = ($urandom_range(0, 2) == 0) || (k >= 8);
      snp = ($urandom_range(0, 5) == 0);
      do_op(rd, wr, at, pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom,
            $urandom_range(1, 5), snp, pool[$urandom_range(0, 3)]);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) snoop_idle(pool[$urandom_range(0, 3)]);
        else begin @(posedge CLK); #1; end
      end
    end

    // watchdog: load with no dhit, then reset mid-access
    cur_lat = 0;
    memren_in = 1'b1; aluout_in = 32'h400;
    @(posedge CLK); #1;
    repeat (MW - 1) @(posedge CLK);
    #1;
    chk("timeout_before_limit", 32'(timeout_err), 32'd0);
    @(posedge CLK); #1;
    chk("timeout_at_limit", 32'(timeout_err), 32'd1);
    repeat (5) @(posedge CLK);
    #1;
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    chk("dmemREN_waiting", 32'(dmemREN), 32'd1);
    chk("stall_waiting", 32'(mem_stall), 32'd1);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("rst_mid_dmemREN", 32'(dmemREN), 32'd0);
    chk("rst_mid_dmemaddr", dmemaddr, 32'd0);
    chk("rst_mid_timeout", 32'(timeout_err), 32'd0);
    memren_in = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(mem_stall), 32'd0);
    m_lv = 1'b0; m_ld = '0; m_sc = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    do_op(1, 0, 0, 32'h100, 32'h0, 2, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
